// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one load/store per MEM instruction on the
// split-handshake data bus (req/addr_ok, data_ok), stalls the pipeline and aligns/extends data.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic [2:0]        l_s_typeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              flushM,
  input  logic              ext_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wen,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] rdataM,
  output logic              stall_mem,
  output logic              addr_err_load,
  output logic              addr_err_store,
  output logic [ADDR_W-1:0] bad_vaddrM
);

  // Access-type encodings, identical to defines2.vh.
  localparam logic [2:0] LB_TYPE  = 3'd0;
  localparam logic [2:0] LBU_TYPE = 3'd1;
  localparam logic [2:0] LH_TYPE  = 3'd2;
  localparam logic [2:0] LHU_TYPE = 3'd3;
  localparam logic [2:0] LW_TYPE  = 3'd4;
  localparam logic [2:0] SB_TYPE  = 3'd5;
  localparam logic [2:0] SH_TYPE  = 3'd6;
  localparam logic [2:0] SW_TYPE  = 3'd7;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hold_q;

  logic              misaligned;
  logic              is_store;
  logic              err_any;
  logic              legal;
  logic              capture;
  logic              latch;

  logic [2:0]        cur_type;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        byte_wen, half_wen;
  logic [DATA_W-1:0] byte_wdata, half_wdata;

  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wen;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] load_ext;

  // Alignment is judged on the live MEM inputs, independent of the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    case (l_s_typeM)
      LH_TYPE, LHU_TYPE, SH_TYPE: misaligned = addrM[0];
      LW_TYPE, SW_TYPE:           misaligned = |addrM[1:0];
      default:                    misaligned = 1'b0;
    endcase
  end

  assign is_store       = (l_s_typeM == SB_TYPE) || (l_s_typeM == SH_TYPE) ||
                          (l_s_typeM == SW_TYPE);
  assign err_any        = resetn & mem_en & misaligned;
  assign addr_err_load  = err_any & ~is_store;
  assign addr_err_store = err_any & is_store;
  assign bad_vaddrM     = err_any ? addrM : '0;
  assign legal          = mem_en & ~misaligned & ~flushM;

  // Once issued, the bus sees only the captured request fields.
  assign cur_type  = (state_q == S_IDLE) ? l_s_typeM : type_q;
  assign cur_addr  = (state_q == S_IDLE) ? addrM     : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? wdataM    : wdata_q;

  // Byte lanes are big-endian within the word: offset 00 is bits 31:24.
  always_comb begin
    rd_byte    = data_rdata[7:0];
    byte_wen   = 4'b0001;
    byte_wdata = {24'h0, cur_wdata[7:0]};
    case (cur_addr[1:0])
      2'b00: begin
        rd_byte    = data_rdata[31:24];
        byte_wen   = 4'b1000;
        byte_wdata = {cur_wdata[7:0], 24'h0};
      end
      2'b01: begin
        rd_byte    = data_rdata[23:16];
        byte_wen   = 4'b0100;
        byte_wdata = {8'h0, cur_wdata[7:0], 16'h0};
      end
      2'b10: begin
        rd_byte    = data_rdata[15:8];
        byte_wen   = 4'b0010;
        byte_wdata = {16'h0, cur_wdata[7:0], 8'h0};
      end
      default: begin
        rd_byte    = data_rdata[7:0];
        byte_wen   = 4'b0001;
        byte_wdata = {24'h0, cur_wdata[7:0]};
      end
    endcase
  end

  always_comb begin
    if (cur_addr[1]) begin
      rd_half    = data_rdata[15:0];
      half_wen   = 4'b0011;
      half_wdata = {16'h0, cur_wdata[15:0]};
    end else begin
      rd_half    = data_rdata[31:16];
      half_wen   = 4'b1100;
      half_wdata = {cur_wdata[15:0], 16'h0};
    end
  end

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd2;
    bus_wen   = 4'b0000;
    bus_wdata = '0;
    load_ext  = data_rdata;
    case (cur_type)
      LB_TYPE: begin
        bus_size = 2'd0;
        load_ext = {{24{rd_byte[7]}}, rd_byte};
      end
      LBU_TYPE: begin
        bus_size = 2'd0;
        load_ext = {24'h0, rd_byte};
      end
      LH_TYPE: begin
        bus_size = 2'd1;
        load_ext = {{16{rd_half[15]}}, rd_half};
      end
      LHU_TYPE: begin
        bus_size = 2'd1;
        load_ext = {16'h0, rd_half};
      end
      LW_TYPE: begin
        bus_size = 2'd2;
        load_ext = data_rdata;
      end
      SB_TYPE: begin
        bus_wr    = 1'b1;
        bus_size  = 2'd0;
        bus_wen   = byte_wen;
        bus_wdata = byte_wdata;
      end
      SH_TYPE: begin
        bus_wr    = 1'b1;
        bus_size  = 2'd1;
        bus_wen   = half_wen;
        bus_wdata = half_wdata;
      end
      default: begin
        bus_wr    = 1'b1;
        bus_size  = 2'd2;
        bus_wen   = 4'b1111;
        bus_wdata = cur_wdata;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, even with live inputs present.
  assign data_req   = resetn & (((state_q == S_IDLE) & legal) |
                                ((state_q == S_REQ) & ~flushM));
  assign stall_mem  = resetn & (((state_q == S_IDLE) & legal) |
                                (state_q == S_REQ) | (state_q == S_WAIT) |
                                (state_q == S_DRAIN));
  assign data_wr    = resetn & bus_wr;
  assign data_size  = resetn ? bus_size  : 2'd0;
  assign data_addr  = resetn ? cur_addr  : '0;
  assign data_wen   = resetn ? bus_wen   : 4'b0000;
  assign data_wdata = resetn ? bus_wdata : '0;
  assign rdataM     = hold_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (legal) begin
          capture = 1'b1;
          if (data_addr_ok) begin
            latch   = data_data_ok;
            state_d = data_data_ok ? S_DONE : S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flushM) begin
          state_d = S_IDLE;
        end else if (data_addr_ok) begin
          latch   = data_data_ok;
          state_d = data_data_ok ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          latch   = 1'b1;
          state_d = S_DONE;
        end else if (flushM) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  if (!ext_stall)   state_d = S_IDLE;
      S_DRAIN: if (data_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      type_q  <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (capture) begin
        type_q  <= l_s_typeM;
        addr_q  <= addrM;
        wdata_q <= wdataM;
      end
      // Only loads carry a result; a store completion leaves the hold register alone.
      if (latch && !bus_wr) hold_q <= load_ext;
    end
  end

endmodule
